cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller: the initiator that drives the cache storage block (`cacheBlock`, 1024 lines × 128-bit data plus flag RAM). It also drives the CPU response and the memory refill/writeback port. It sequences lookup, tag compare, store-hit byte writes, dirty-victim writeback, line refill and post-reset invalidation. It sits between the CPU load/store port and the memory bus, one instance per cache.

---
 rtl/cache_ctrl_pkg.sv | 35 +++
 rtl/cache_line_merge.sv | 25 ++
 rtl/cache_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared widths, state encoding and small helpers for the cache controller.
package cache_ctrl_pkg;

  localparam int Index_Width      = 10;
  localparam int Tag_Width        = 18;
  localparam int Cache_Block_Size = 128;
  localparam int En_Word_Width    = 4;
  localparam int En_Byte_Width    = 4;
  localparam int Offset_Width     = 4;
  localparam int Word_Sel_Width   = 2;
  localparam int Word_Width       = 32;

  typedef enum logic [2:0] {
    STATE_INIT,
    STATE_IDLE,
    STATE_LOOKUP,
    STATE_WB,
    STATE_REFILL,
    STATE_FILL
  } state_t;

  // Byte-lane patterns the storage block can write as a partial word
  function automatic logic be_legal(input logic [En_Byte_Width-1:0] be);
    case (be)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
      default:                            be_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [En_Word_Width-1:0] word_onehot(input logic [Word_Sel_Width-1:0] w);
    word_onehot = 4'b0001 << w;
  endfunction

endpackage

// File: rtl/cache_line_merge.sv
// Combinational line helper: overlays store bytes onto a line and selects the read word.
module cache_line_merge
  import cache_ctrl_pkg::*;
(
  input  logic [Cache_Block_Size-1:0] line_i,
  input  logic [Word_Sel_Width-1:0]   word_i,
  input  logic [En_Byte_Width-1:0]    be_i,
  input  logic [Word_Width-1:0]       wdata_i,
  output logic [Cache_Block_Size-1:0] line_o,
  output logic [Word_Width-1:0]       word_o
);

  // Replace the enabled byte lanes of the selected word with store data
  always_comb begin
    line_o = line_i;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (word_i == 2'(w) && be_i[b]) line_o[w*32 + b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end
  end

  assign word_o = line_i[{word_i, 5'b0} +: Word_Width];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller driving the line storage block.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [3:0]   cpu_be,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic         cpu_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [9:0]   blk_index,
  output logic [3:0]   blk_en_word,
  output logic [3:0]   blk_en_byte,
  output logic         blk_wr,
  output logic         blk_valid_new,
  output logic         blk_dirty_new,
  output logic [17:0]  blk_tag_in,
  output logic [127:0] blk_data_in,
  input  logic         blk_valid,
  input  logic         blk_dirty,
  input  logic [17:0]  blk_tag,
  input  logic [127:0] blk_data
);

  state_t                      state_q, state_d;
  logic [Index_Width-1:0]      cnt_q, cnt_d;
  logic                        we_q, we_d;
  logic [31:2]                 addr_q, addr_d;
  logic [3:0]                  be_q, be_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [Tag_Width-1:0]        vtag_q, vtag_d;
  logic [Cache_Block_Size-1:0] victim_q, victim_d;
  logic [Cache_Block_Size-1:0] line_q, line_d;

  logic [Tag_Width-1:0]        tag;
  logic [Index_Width-1:0]      idx;
  logic [Word_Sel_Width-1:0]   word;
  logic                        hit;
  logic [Cache_Block_Size-1:0] merge_src, merge_line;
  logic [Word_Width-1:0]       merge_word;
  logic                        unused_addr_lsb;

  assign tag  = addr_q[31:14];
  assign idx  = addr_q[13:4];
  assign word = addr_q[3:2];
  assign hit  = blk_valid && (blk_tag == tag);

  // Byte offset never reaches the cache; lanes come from cpu_be
  assign unused_addr_lsb = ^cpu_addr[1:0];

  // LOOKUP reads from the block output, FILL from the latched refill line
  assign merge_src = (state_q == STATE_FILL) ? line_q : blk_data;

  cache_line_merge u_merge (
    .line_i  (merge_src),
    .word_i  (word),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .line_o  (merge_line),
    .word_o  (merge_word)
  );

  // Next-state, latches and all block/CPU/memory strobes
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    vtag_d        = vtag_q;
    victim_d      = victim_q;
    line_d        = line_q;
    cpu_rdata     = '0;
    cpu_ready     = 1'b0;
    cpu_err       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    blk_index     = idx;
    blk_en_word   = '0;
    blk_en_byte   = '0;
    blk_wr        = 1'b0;
    blk_valid_new = 1'b0;
    blk_dirty_new = 1'b0;
    blk_tag_in    = '0;
    blk_data_in   = '0;
    case (state_q)
      STATE_INIT: begin
        // Invalidate one line per cycle; all-zero enables mean full-line write
        blk_index = cnt_q;
        blk_wr    = 1'b1;
        cnt_d     = cnt_q + 10'd1;
        if (cnt_q == '1) state_d = STATE_IDLE;
      end
      STATE_IDLE: begin
        blk_index = cpu_addr[13:4];
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr[31:2];
          be_d    = cpu_be;
          wdata_d = cpu_wdata;
          state_d = STATE_LOOKUP;
        end
      end
      STATE_LOOKUP: begin
        if (we_q && !be_legal(be_q)) begin
          cpu_ready = 1'b1;
          cpu_err   = 1'b1;
          state_d   = STATE_IDLE;
        end else if (hit) begin
          cpu_ready = 1'b1;
          state_d   = STATE_IDLE;
          if (we_q) begin
            blk_wr        = 1'b1;
            blk_en_word   = word_onehot(word);
            blk_en_byte   = be_q;
            blk_data_in   = {4{wdata_q}};
            blk_tag_in    = tag;
            blk_valid_new = 1'b1;
            blk_dirty_new = 1'b1;
          end else begin
            cpu_rdata = merge_word;
          end
        end else if (blk_valid && blk_dirty) begin
          vtag_d   = blk_tag;
          victim_d = blk_data;
          state_d  = STATE_WB;
        end else begin
          state_d = STATE_REFILL;
        end
      end
      STATE_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vtag_q, idx, {Offset_Width{1'b0}}};
        mem_wdata = victim_q;
        if (mem_ready) state_d = STATE_REFILL;
      end
      STATE_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, {Offset_Width{1'b0}}};
        if (mem_ready) begin
          line_d  = mem_rdata;
          state_d = STATE_FILL;
        end
      end
      STATE_FILL: begin
        blk_wr        = 1'b1;
        blk_tag_in    = tag;
        blk_valid_new = 1'b1;
        blk_dirty_new = we_q;
        blk_data_in   = we_q ? merge_line : line_q;
        cpu_rdata     = we_q ? '0 : merge_word;
        cpu_ready     = 1'b1;
        state_d       = STATE_IDLE;
      end
      default: state_d = STATE_INIT;
    endcase
  end

  // State and latched request/line registers; reset restarts the invalidation sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STATE_INIT;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      vtag_q   <= '0;
      victim_q <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      vtag_q   <= vtag_d;
      victim_q <= victim_d;
      line_q   <= line_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: storage-block and memory models, golden word memory, response scoreboard.
module tb_cache_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]   cpu_be;
  logic         cpu_ready, cpu_err;
  logic         mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [9:0]   blk_index;
  logic [3:0]   blk_en_word, blk_en_byte;
  logic         blk_wr, blk_valid_new, blk_dirty_new;
  logic [17:0]  blk_tag_in, blk_tag;
  logic [127:0] blk_data_in, blk_data;
  logic         blk_valid, blk_dirty;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .blk_index(blk_index), .blk_en_word(blk_en_word), .blk_en_byte(blk_en_byte),
    .blk_wr(blk_wr), .blk_valid_new(blk_valid_new), .blk_dirty_new(blk_dirty_new),
    .blk_tag_in(blk_tag_in), .blk_data_in(blk_data_in),
    .blk_valid(blk_valid), .blk_dirty(blk_dirty), .blk_tag(blk_tag), .blk_data(blk_data)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- storage block model (1-cycle read latency) ----------------
  logic [127:0] bdata [1024];
  logic [17:0]  btag  [1024];
  logic         bval  [1024];
  logic         bdirty[1024];

  function automatic logic [127:0] blk_wmerge(input logic [127:0] old, input logic [3:0] ew,
                                              input logic [3:0] eb, input logic [127:0] din);
    logic [127:0] r;
    r = old;
    if ((ew inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) &&
        (eb inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000})) begin
      for (int w = 0; w < 4; w++)
        for (int b = 0; b < 4; b++)
          if (ew[w] && eb[b]) r[w*32 + b*8 +: 8] = din[w*32 + b*8 +: 8];
    end else begin
      r = din;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (blk_wr) begin
      bdata[blk_index]  <= blk_wmerge(bdata[blk_index], blk_en_word, blk_en_byte, blk_data_in);
      btag[blk_index]   <= blk_tag_in;
      bval[blk_index]   <= blk_valid_new;
      bdirty[blk_index] <= blk_dirty_new;
    end
    blk_data  <= bdata[blk_index];
    blk_tag   <= btag[blk_index];
    blk_valid <= bval[blk_index];
    blk_dirty <= bdirty[blk_index];
  end

  // ---------------- golden memory / backing store ----------------
  function automatic logic [31:0] init_word(input logic [29:0] wa);
    if (wa == 30'h401) return 32'hDEADBEEF;
    return {wa[13:0], 2'b01, wa[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  logic [31:0]  gold      [logic [29:0]];
  logic [127:0] mem_store [logic [27:0]];

  function automatic logic [31:0] gold_rd(input logic [29:0] wa);
    return gold.exists(wa) ? gold[wa] : init_word(wa);
  endfunction

  function automatic logic [127:0] gold_line(input logic [27:0] la);
    return {gold_rd({la, 2'd3}), gold_rd({la, 2'd2}), gold_rd({la, 2'd1}), gold_rd({la, 2'd0})};
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    if (mem_store.exists(la)) return mem_store[la];
    return {init_word({la, 2'd3}), init_word({la, 2'd2}), init_word({la, 2'd1}), init_word({la, 2'd0})};
  endfunction

  typedef struct { logic we; logic [31:0] addr; logic [127:0] data; } mtx_t;
  mtx_t mlog[$];

  // Memory slave: each transaction completes after two cycles of mem_req
  initial begin
    int mlat;
    mlat = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) mem_ready = 1'b0;
      else if (rst || !mem_req) mlat = 0;
      else begin
        mlat++;
        if (mlat == 2) begin
          mlat = 0;
          mem_ready = 1'b1;
          mlog.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_line(mem_addr[31:4])});
          if (mem_we) mem_store[mem_addr[31:4]] = mem_wdata;
          else        mem_rdata = mem_line(mem_addr[31:4]);
        end
      end
    end
  end

  // ---------------- response scoreboard ----------------
  typedef struct { logic err; logic ld; logic [31:0] rdata; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst && cpu_ready) begin
      if (sb.size() == 0) chk("unexpected_ready", 1'b1, 1'b0);
      else begin
        e = sb.pop_front();
        chk("cpu_err", cpu_err, e.err);
        if (e.ld && !e.err) chk("cpu_rdata", cpu_rdata, e.rdata);
      end
    end
  end

  // Issue one request from a negedge with the controller idle; return when it is back in IDLE
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output int lat, output logic saw_mem,
                        output logic saw_wr, output logic [3:0] ew, output logic [3:0] eb,
                        output logic dn, output logic wr_rdy);
    exp_t e;
    logic legal;
    logic [31:0] g;
    legal   = be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    e.err   = we && !legal;
    e.ld    = !we;
    e.rdata = gold_rd(addr[31:2]);
    if (we && legal) begin
      g = gold_rd(addr[31:2]);
      for (int b = 0; b < 4; b++) if (be[b]) g[b*8 +: 8] = wd[b*8 +: 8];
      gold[addr[31:2]] = g;
    end
    sb.push_back(e);
    mlog.delete();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    lat = 0; saw_mem = 1'b0; saw_wr = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_req) saw_mem = 1'b1;
      if (blk_wr)  saw_wr  = 1'b1;
    end while (!cpu_ready && lat < 300);
    if (!cpu_ready) chk("req_timeout", 1'b0, 1'b1);
    ew = blk_en_word; eb = blk_en_byte; dn = blk_dirty_new; wr_rdy = blk_wr;
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  // Verify the 1024-cycle invalidation sweep starting at the current negedge
  task automatic init_sweep(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!(blk_wr === 1'b1 && blk_valid_new === 1'b0 && blk_dirty_new === 1'b0 &&
            blk_index === 10'(i) && blk_en_word === 4'b0 && blk_en_byte === 4'b0 &&
            blk_tag_in === 18'b0 && blk_data_in === 128'b0 && mem_req === 1'b0)) bad++;
      @(negedge clk);
    end
    chk({tag, "_sweep_bad_cycles"}, bad, 0);
    chk({tag, "_idle_no_wr"}, blk_wr, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] legal_be [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    int lat, wait_n;
    logic sm, sw, dn, wr;
    logic [3:0] ew, eb, be;
    logic [127:0] victim;
    logic [31:0] a;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_cpu_err", cpu_err, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_blk_wr", blk_wr, 1'b1);
    chk("rst_blk_index", blk_index, 10'h0);
    chk("rst_valid_new", blk_valid_new, 1'b0);
    rst = 1'b0;
    init_sweep("init");

    // Cold miss: clean refill of line 0x1000
    do_req(1'b0, 32'h0000_1000, 4'hF, 32'h0, lat, sm, sw, ew, eb, dn, wr);
    chk("cold_mem_count", mlog.size(), 1);
    if (mlog.size() == 1) begin
      chk("cold_mem_we", mlog[0].we, 1'b0);
      chk("cold_mem_addr", mlog[0].addr, 32'h0000_1000);
    end
    chk("cold_fill_dirty_new", dn, 1'b0);

    // Load hit returns word 1 of the refilled line
    do_req(1'b0, 32'h0000_1004, 4'hF, 32'h0, lat, sm, sw, ew, eb, dn, wr);
    chk("hit_latency", lat, 1);
    chk("hit_no_mem", sm, 1'b0);

    // Store hit into byte 2 of word 1
    do_req(1'b1, 32'h0000_1006, 4'b0100, 32'h00AB_0000, lat, sm, sw, ew, eb, dn, wr);
    chk("st_latency", lat, 1);
    chk("st_blk_wr", wr, 1'b1);
    chk("st_en_word", ew, 4'b0010);
    chk("st_en_byte", eb, 4'b0100);
    chk("st_dirty_new", dn, 1'b1);
    chk("st_no_mem", sm, 1'b0);

    // Back-to-back load sees the merged word
    do_req(1'b0, 32'h0000_1004, 4'hF, 32'h0, lat, sm, sw, ew, eb, dn, wr);
    chk("ld_after_st_latency", lat, 1);

    // Conflict miss with dirty victim: writeback then refill
    victim = gold_line(28'h0000_100);
    do_req(1'b0, 32'h0000_5000, 4'hF, 32'h0, lat, sm, sw, ew, eb, dn, wr);
    chk("dirty_mem_count", mlog.size(), 2);
    if (mlog.size() == 2) begin
      chk("wb_we", mlog[0].we, 1'b1);
      chk("wb_addr", mlog[0].addr, 32'h0000_1000);
      chk("wb_data", mlog[0].data, victim);
      chk("rf_we", mlog[1].we, 1'b0);
      chk("rf_addr", mlog[1].addr, 32'h0000_5000);
    end
    chk("dirty_fill_wr", wr, 1'b1);
    chk("dirty_fill_dirty_new", dn, 1'b0);

    // Illegal byte-lane pattern on a store
    do_req(1'b1, 32'h0000_2000, 4'b0110, 32'h1234_5678, lat, sm, sw, ew, eb, dn, wr);
    chk("bad_be_latency", lat, 1);
    chk("bad_be_no_wr", sw, 1'b0);
    chk("bad_be_no_mem", sm, 1'b0);

    // Reset while REFILL is outstanding
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_9000; cpu_be = 4'hF;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!(mem_req && !mem_we) && wait_n < 50);
    chk("reach_refill", mem_req && !mem_we, 1'b1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_cpu_ready", cpu_ready, 1'b0);
    chk("midrst_blk_index", blk_index, 10'h0);
    rst = 1'b0;
    init_sweep("midrst");

    // Written-back line comes back from memory after the re-invalidation
    do_req(1'b0, 32'h0000_1004, 4'hF, 32'h0, lat, sm, sw, ew, eb, dn, wr);
    chk("post_rst_refill", sm, 1'b1);

    // Mixed traffic on two indices with four competing tags
    for (int i = 0; i < 60; i++) begin
      a = {18'($urandom_range(0, 3)), 10'(16 + $urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'b00};
      be = legal_be[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) be = 4'b0101;
      do_req(1'($urandom_range(0, 1)), a, be, $urandom, lat, sm, sw, ew, eb, dn, wr);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
